// File: rtl/lsu_mem_port.sv
// Memory-stage load/store port: one word-wide bus transaction per request, with byte enables.
// Optional bus abort after MAX_WAIT cycles is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_port #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        store_src,
    input  logic [2:0]        load_part,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              timeout,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    state_e            state_q, state_d;
    logic [1:0]        off_q, size_q;
    logic              signed_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              legal, aligned, accept, ld_signed, abort;
    logic [1:0]        size;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new, lane, load_ext;

    // Request decode: size class, signedness, legality and alignment.
    always_comb begin
        legal     = 1'b1;
        size      = SzWord;
        ld_signed = 1'b0;
        if (req_we) begin
            case (store_src)
                2'b00:   size = SzWord;
                2'b01:   size = SzHalf;
                2'b10:   size = SzByte;
                default: legal = 1'b0;
            endcase
        end else begin
            case (load_part)
                3'b000: begin size = SzByte; ld_signed = 1'b1; end
                3'b001: begin size = SzHalf; ld_signed = 1'b1; end
                3'b010:  size = SzWord;
                3'b100:  size = SzByte;
                3'b101:  size = SzHalf;
                default: legal = 1'b0;
            endcase
        end
        case (size)
            SzByte:  aligned = 1'b1;
            SzHalf:  aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign accept = (state_q == StIdle) && req_valid && legal && aligned;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata;
        case (size)
            SzByte: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            SzHalf: begin
                be_new    = 4'b0011 << {addr[1], 1'b0};
                wdata_new = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = lane;
        case (size_q)
            SzByte:  load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
            SzHalf:  load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Abort once MAX_WAIT cycles have already been spent in the current wait state.
    assign abort = ((state_q == StAddr) || (state_q == StResp)) &&
                   (cnt_q == CntW'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == StAddr) || (state_q == StResp)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StAddr;
            end
            StAddr: begin
                if (abort) begin
                    rdata_d = '0;
                    state_d = StDone;
                end else if (bus_ready) begin
                    state_d = bus_we_q ? StDone : StResp;
                end
            end
            StResp: begin
                if (bus_rvalid) begin
                    rdata_d = load_ext;
                    state_d = StDone;
                end else if (abort) begin
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            off_q       <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (accept) begin
                off_q       <= addr[1:0];
                size_q      <= size;
                signed_q    <= ld_signed;
                bus_we_q    <= req_we;
                bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                bus_be_q    <= be_new;
                bus_wdata_q <= wdata_new;
            end
        end
    end

    assign stall       = (state_q == StAddr) || (state_q == StResp) || accept;
    assign misalign    = (state_q == StIdle) && req_valid && !(legal && aligned);
    assign timeout     = abort;
    assign bus_valid   = (state_q == StAddr) && !abort;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == StDone) && !bus_we_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port; inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_lsu_mem_port;

    logic        clk, reset_n;
    logic        req_valid, req_we;
    logic [1:0]  store_src;
    logic [2:0]  load_part;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, misalign, timeout;
    logic [31:0] rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int failures = 0;

    lsu_mem_port #(.ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .store_src   (store_src),
        .load_part   (load_part),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .timeout     (timeout),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [1:0] src,
                           input logic [2:0] part, input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        store_src = src;
        load_part = part;
        addr      = a;
        wdata     = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".stall"}, {31'b0, stall}, 32'd0);
        check({tag, ".bus_valid"}, {31'b0, bus_valid}, 32'd0);
        check({tag, ".bus_be"}, {28'b0, bus_be}, 32'd0);
        check({tag, ".bus_addr"}, bus_addr, 32'd0);
        check({tag, ".bus_wdata"}, bus_wdata, 32'd0);
        check({tag, ".bus_we"}, {31'b0, bus_we}, 32'd0);
        check({tag, ".rdata"}, rdata, 32'd0);
        check({tag, ".rdata_valid"}, {31'b0, rdata_valid}, 32'd0);
        check({tag, ".misalign"}, {31'b0, misalign}, 32'd0);
        check({tag, ".timeout"}, {31'b0, timeout}, 32'd0);
    endtask

    // Load with zero-wait bus: accept, ADDR(ready), RESP(rvalid), DONE.
    task automatic zero_wait_load(input string tag, input logic [2:0] part, input logic [31:0] a,
                                  input logic [31:0] data, input logic [3:0] exp_be,
                                  input logic [31:0] exp_rdata);
        cyc(); set_req(1'b1, 1'b0, 2'b00, part, a, 32'd0); settle();
        check({tag, ".c0_stall"}, {31'b0, stall}, 32'd1);
        cyc(); bus_ready = 1'b1; settle();
        check({tag, ".c1_valid"}, {31'b0, bus_valid}, 32'd1);
        check({tag, ".c1_be"}, {28'b0, bus_be}, {28'b0, exp_be});
        check({tag, ".c1_addr"}, bus_addr, {a[31:2], 2'b00});
        cyc(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = data; settle();
        check({tag, ".c2_stall"}, {31'b0, stall}, 32'd1);
        check({tag, ".c2_rdv"}, {31'b0, rdata_valid}, 32'd0);
        cyc(); bus_rvalid = 1'b0; bus_rdata = 32'hDEAD_BEEF; settle();
        check({tag, ".c3_stall"}, {31'b0, stall}, 32'd0);
        check({tag, ".c3_rdv"}, {31'b0, rdata_valid}, 32'd1);
        check({tag, ".c3_rdata"}, rdata, exp_rdata);
        cyc(); req_valid = 1'b0; settle();
        check({tag, ".c4_rdv"}, {31'b0, rdata_valid}, 32'd0);
        check({tag, ".c4_stall"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        set_req(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        cyc(); cyc(); settle();
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // 1: SB to byte 3, ready in first ADDR cycle.
        cyc(); set_req(1'b1, 1'b1, 2'b10, 3'b000, 32'h0000_1003, 32'h0000_00A5); settle();
        check("sb.c0_stall", {31'b0, stall}, 32'd1);
        check("sb.c0_valid", {31'b0, bus_valid}, 32'd0);
        cyc(); bus_ready = 1'b1; settle();
        check("sb.c1_stall", {31'b0, stall}, 32'd1);
        check("sb.c1_valid", {31'b0, bus_valid}, 32'd1);
        check("sb.c1_we", {31'b0, bus_we}, 32'd1);
        check("sb.c1_be", {28'b0, bus_be}, 32'h8);
        check("sb.c1_wdata", bus_wdata, 32'hA5A5_A5A5);
        check("sb.c1_addr", bus_addr, 32'h0000_1000);
        cyc(); bus_ready = 1'b0; settle();
        check("sb.c2_stall", {31'b0, stall}, 32'd0);
        check("sb.c2_valid", {31'b0, bus_valid}, 32'd0);
        check("sb.c2_rdv", {31'b0, rdata_valid}, 32'd0);
        cyc(); req_valid = 1'b0; settle();
        check("sb.c3_stall", {31'b0, stall}, 32'd0);

        // 2: LB / LBU from byte 2.
        zero_wait_load("lb", 3'b000, 32'h0000_2002, 32'h0080_FF00, 4'b0100, 32'hFFFF_FF80);
        zero_wait_load("lbu", 3'b100, 32'h0000_2002, 32'h0080_FF00, 4'b0100, 32'h0000_0080);

        // 3: LH upper half, bus_ready held low for 3 ADDR cycles.
        cyc(); set_req(1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'd0); settle();
        check("lh.c0_stall", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus_ready = 1'b0; settle();
            check("lh.wait_valid", {31'b0, bus_valid}, 32'd1);
            check("lh.wait_be", {28'b0, bus_be}, 32'hC);
            check("lh.wait_addr", bus_addr, 32'h0000_2000);
            check("lh.wait_we", {31'b0, bus_we}, 32'd0);
            check("lh.wait_stall", {31'b0, stall}, 32'd1);
        end
        cyc(); bus_ready = 1'b1; settle();
        check("lh.rdy_be", {28'b0, bus_be}, 32'hC);
        cyc(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h8001_1234; settle();
        check("lh.resp_stall", {31'b0, stall}, 32'd1);
        cyc(); bus_rvalid = 1'b0; settle();
        check("lh.done_rdata", rdata, 32'hFFFF_8001);
        check("lh.done_rdv", {31'b0, rdata_valid}, 32'd1);
        cyc(); req_valid = 1'b0; settle();
        check("lh.after_rdv", {31'b0, rdata_valid}, 32'd0);

        // 4: misaligned and illegal requests.
        cyc(); set_req(1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_3001, 32'h1234_5678); settle();
        check("sw_mis.misalign", {31'b0, misalign}, 32'd1);
        check("sw_mis.stall", {31'b0, stall}, 32'd0);
        check("sw_mis.valid", {31'b0, bus_valid}, 32'd0);
        cyc(); req_valid = 1'b0; settle();
        check("sw_mis.next_valid", {31'b0, bus_valid}, 32'd0);
        check("sw_mis.next_misalign", {31'b0, misalign}, 32'd0);
        cyc(); set_req(1'b1, 1'b1, 2'b11, 3'b000, 32'h0000_3000, 32'd0); settle();
        check("ill_src.misalign", {31'b0, misalign}, 32'd1);
        check("ill_src.stall", {31'b0, stall}, 32'd0);
        cyc(); set_req(1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_3000, 32'd0); settle();
        check("ill_part.misalign", {31'b0, misalign}, 32'd1);
        check("ill_part.stall", {31'b0, stall}, 32'd0);
        cyc(); set_req(1'b1, 1'b0, 2'b00, 3'b101, 32'h0000_3001, 32'd0); settle();
        check("lhu_mis.misalign", {31'b0, misalign}, 32'd1);
        cyc(); req_valid = 1'b0; settle();
        check("mis.end_valid", {31'b0, bus_valid}, 32'd0);

        // 5: reset in RESP, late bus_rvalid ignored.
        cyc(); set_req(1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_4000, 32'd0); settle();
        cyc(); bus_ready = 1'b1; settle();
        cyc(); bus_ready = 1'b0; req_valid = 1'b0; reset_n = 1'b0; settle();
        check("rst.resp_stall", {31'b0, stall}, 32'd1);
        cyc(); settle();
        check_idle_outputs("rst.in");
        cyc(); reset_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D; settle();
        check("rst.late_rdv", {31'b0, rdata_valid}, 32'd0);
        check("rst.late_stall", {31'b0, stall}, 32'd0);
        cyc(); bus_rvalid = 1'b0; settle();
        check("rst.after_rdv", {31'b0, rdata_valid}, 32'd0);
        check("rst.after_rdata", rdata, 32'd0);

        // 6: LW with bus_ready never asserted.
        cyc(); set_req(1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_5000, 32'd0); settle();
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            cyc(); settle();
            check("to.wait_valid", {31'b0, bus_valid}, 32'd1);
            check("to.wait_timeout", {31'b0, timeout}, 32'd0);
        end
        cyc(); settle();
        check("to.abort_timeout", {31'b0, timeout}, 32'd1);
        check("to.abort_valid", {31'b0, bus_valid}, 32'd0);
        cyc(); settle();
        check("to.done_rdv", {31'b0, rdata_valid}, 32'd1);
        check("to.done_rdata", rdata, 32'd0);
        check("to.done_timeout", {31'b0, timeout}, 32'd0);
        cyc(); req_valid = 1'b0; settle();
        check("to.idle_stall", {31'b0, stall}, 32'd0);
`else
        for (int i = 0; i < 30; i++) begin
            cyc(); settle();
            check("hang.stall", {31'b0, stall}, 32'd1);
            check("hang.timeout", {31'b0, timeout}, 32'd0);
        end
        check("hang.valid", {31'b0, bus_valid}, 32'd1);
        cyc(); req_valid = 1'b0; reset_n = 1'b0; settle();
        cyc(); reset_n = 1'b1; settle();
        check("hang.reset_stall", {31'b0, stall}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Memory-stage load/store port; the execution end of the StoreSrc/LoadPart control encoding produced by the decode-stage control unit. Takes one load or store request from the M stage and runs it as a single word-wide data-bus transaction with byte enables. Returns sign- or zero-extended load data. Stalls the pipeline until the transaction completes.

Parameters:
ADDR_W, 32, byte-address width of addr and bus_addr.
MAX_WAIT, 15, cycles allowed in ADDR or RESP before abort; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  synchronous active-low reset.
req_valid  in  1  M stage holds a load/store.
req_we  in  1  1 = store (MemWriteM), 0 = load.
store_src  in  2  store size: 00 SW, 01 SH, 10 SB, 11 illegal.
load_part  in  3  load kind: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others illegal.
addr  in  ADDR_W  byte address (ALU result).
wdata  in  32  store data (rs2).
stall  out  1  freeze pipeline stages F..M.
rdata  out  32  extended load result; valid while rdata_valid=1.
rdata_valid  out  1  one-cycle pulse in DONE for loads.
misalign  out  1  one-cycle pulse: misaligned access or illegal size code.
timeout  out  1  one-cycle pulse on bus abort.
bus_valid  out  1  request valid.
bus_ready  in  1  request accepted.
bus_we  out  1  write request.
bus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00.
bus_be  out  4  byte-lane enables.
bus_wdata  out  32  lane-replicated write data.
bus_rvalid  in  1  read data valid.
bus_rdata  in  32  read data.

Behaviour:
- FSM states: IDLE, ADDR, RESP, DONE. Reset: state IDLE; all outputs 0, including registered bus fields and rdata.
- IDLE, req_valid=1, legal and aligned: capture addr[1:0], size code, req_we; register bus fields; go to ADDR. stall is combinational 1 in this cycle.
- IDLE, req_valid=1, illegal or misaligned: pulse misalign. No bus transaction. stall=0, so the instruction retires with no effect.
- Misaligned: SW or LW with addr[1:0]≠00; SH, LH or LHU with addr[0]=1. SB, LB and LBU are never misaligned.
- ADDR: bus_valid=1. bus_addr, bus_be, bus_we and bus_wdata stay stable until bus_ready. On bus_ready, a store goes to DONE and a load goes to RESP.
- RESP: wait for bus_rvalid, which is sampled only in RESP and ignored in every other state. On bus_rvalid, register the extended data and go to DONE.
- DONE: stall=0. Pulse rdata_valid for loads. Go to IDLE unconditionally. req_valid in DONE is the completing instruction and is never re-accepted.
- stall = (state≠IDLE and state≠DONE) or (state=IDLE and req_valid and legal and aligned).
- Byte enables, little-endian:
  - SB/LB/LBU: bus_be = 0001 << addr[1:0].
  - SH/LH/LHU: bus_be = 0011 << (2·addr[1]).
  - SW/LW: bus_be = 1111.
- Write data: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves; SW passes wdata through.
- Load extract: lane = bus_rdata >> (8·addr[1:0]). LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- Zero-wait latency:
  - Store: 3 cycles (IDLE, ADDR, DONE); stall high for 2.
  - Load: 4 cycles (IDLE, ADDR, RESP, DONE); rdata_valid in cycle 3.
- Reset while in ADDR or RESP: next state IDLE, outputs 0. The outstanding transaction is abandoned and a late bus_rvalid is ignored.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to ADDR and to RESP and increments each cycle spent there. If it reaches MAX_WAIT without bus_ready (ADDR) or bus_rvalid (RESP), drop bus_valid, pulse timeout and go to DONE. A load then returns rdata=0 with rdata_valid=1.
- Undefined: no counter, the port waits indefinitely, and timeout is tied to 0.

Test Plan:
1. SB addr=0x1003, wdata=0x000000A5, bus_ready in the first ADDR cycle -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000; stall high 2 cycles; no rdata_valid.
2. LB addr=0x2002, bus_rdata=0x0080FF00, zero-wait -> rdata=0xFFFFFF80, one rdata_valid pulse in cycle 3. LBU, same data -> rdata=0x00000080.
3. LH addr=0x2002, bus_rdata=0x8001_1234 -> bus_be=1100, rdata=0xFFFF8001. bus_ready held low 3 cycles -> bus fields stable throughout; stall extended by 3 cycles.
4. SW addr=0x3001 -> misalign pulse, bus_valid never asserted, stall=0. store_src=11 and load_part=011 give the same response.
5. LW issued, reset_n=0 in RESP, then bus_rvalid arrives after reset -> state IDLE, all outputs 0, no rdata_valid.
6. With LSU_TIMEOUT_EN and MAX_WAIT=15: LW with bus_ready=0 forever -> after 15 ADDR cycles, timeout pulses, then rdata=0 with rdata_valid; without the macro, stall stays high.
